bist_response_analyzer: RTL and testbench

- Receive-side counterpart of the BIST controller: it compacts circuit-under-test (CUT) responses into a multiple-input signature register (MISR) while the controller reports a test in progress.
- On end of test it checks the signature and the vector and group counts against expected values, then reports PASS/FAIL.
- It sits beside the BIST controller and consumes that controller's RUNNING, OUT and BIST_END outputs directly.

---
 rtl/bist_response_analyzer.sv | 148 ++++++++++++++
 tb/tb_bist_response_analyzer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer
//   Compacts CUT responses into an 8-bit MISR while the BIST controller
//   reports a run. At end of test it checks the signature, the vector
//   count and the group count, and reports PASS or FAIL.
//
//   State   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for RUNNING; captures and group slots still count
//   COMPACT | run in progress, compacting responses
//   COMPARE | one-cycle check of signature and counts
//   DONE    | result held until the controller starts a new run
//
// Ports
//   clk_i        sole clock, rising edge
//   rst_i        asynchronous active-high reset
//   running_i    controller test-in-progress flag
//   out_i        1 = valid vector cycle, 0 = group-boundary slot
//   bist_end_i   controller end-of-test flag
//   cut_resp_i   CUT response, sampled on capture cycles
//   signature_o  current MISR contents
//   busy_o       high in COMPACT and COMPARE
//   done_o       high in DONE
//   pass_o       result valid and correct
//   fail_o       result valid and incorrect (or run aborted)
//   aborted_o    RUNNING fell before BIST_END
module bist_response_analyzer #(
  parameter int             W      = 8,
  parameter logic [W-1:0]   POLY   = 'h1D,
  parameter logic [W-1:0]   SEED   = '0,
  parameter logic [W-1:0]   GOLDEN = '0,
  parameter int             N      = 9,
  parameter int             M      = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         running_i,
  input  logic         out_i,
  input  logic         bist_end_i,
  input  logic [W-1:0] cut_resp_i,
  output logic [W-1:0] signature_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic         fail_o,
  output logic         aborted_o
);

  localparam logic [7:0] VEC_EXP = 8'(N * M);
  localparam logic [3:0] GRP_EXP = 4'(M);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPACT = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t       state_q;
  logic [W-1:0] misr_q;
  logic [W-1:0] misr_d;
  logic [7:0]   vec_q;
  logic [3:0]   grp_q;
  logic         pass_q;
  logic         fail_q;
  logic         aborted_q;

  logic capture;
  logic boundary;
  logic match;

  // BIST_END masks both capture and group counting on the cycle it is seen.
  assign capture  = running_i && out_i && !bist_end_i;
  assign boundary = running_i && !out_i && !bist_end_i;

  // Galois-style shift with polynomial feedback, then fold in the response.
  assign misr_d = {misr_q[W-2:0], 1'b0} ^ (misr_q[W-1] ? POLY : '0) ^ cut_resp_i;

  assign match = (misr_q == GOLDEN) && (vec_q == VEC_EXP) && (grp_q == GRP_EXP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      misr_q    <= SEED;
      vec_q     <= '0;
      grp_q     <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (capture) begin
            misr_q <= misr_d;
            if (vec_q != 8'hFF) vec_q <= vec_q + 8'd1;
          end
          if (boundary && (grp_q != 4'hF)) grp_q <= grp_q + 4'd1;
          if (running_i) state_q <= S_COMPACT;
        end

        S_COMPACT: begin
          if (bist_end_i) begin
            state_q <= S_COMPARE;
          end else if (!running_i) begin
            state_q   <= S_DONE;
            aborted_q <= 1'b1;
            fail_q    <= 1'b1;
            pass_q    <= 1'b0;
          end else begin
            if (capture) begin
              misr_q <= misr_d;
              if (vec_q != 8'hFF) vec_q <= vec_q + 8'd1;
            end
            if (boundary && (grp_q != 4'hF)) grp_q <= grp_q + 4'd1;
          end
        end

        S_COMPARE: begin
          pass_q  <= match;
          fail_q  <= !match;
          state_q <= S_DONE;
        end

        S_DONE: begin
          // Restart cycle reloads the seed and does not capture.
          if (running_i && !bist_end_i) begin
            state_q   <= S_IDLE;
            misr_q    <= SEED;
            vec_q     <= '0;
            grp_q     <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            aborted_q <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign signature_o = misr_q;
  assign busy_o      = (state_q == S_COMPACT) || (state_q == S_COMPARE);
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
module tb_bist_response_analyzer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       running_i;
  logic       out_i;
  logic       bist_end_i;
  logic [7:0] cut_resp_i;
  logic [7:0] signature_o;
  logic       busy_o;
  logic       done_o;
  logic       pass_o;
  logic       fail_o;
  logic       aborted_o;

  int n_pass  = 0;
  int n_total = 0;

  bist_response_analyzer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .running_i   (running_i),
    .out_i       (out_i),
    .bist_end_i  (bist_end_i),
    .cut_resp_i  (cut_resp_i),
    .signature_o (signature_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .aborted_o   (aborted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock, return 1 time unit after the rising edge.
  task automatic step(input logic r, input logic o, input logic e, input logic [7:0] d);
    running_i  = r;
    out_i      = o;
    bist_end_i = e;
    cut_resp_i = d;
    @(posedge clk_i);
    #1;
  endtask

  // Vectors of 0x00 (0x01 at bad_idx), a boundary slot after every 9th
  // vector, any slots still owed appended at the end.
  task automatic run_body(input int nvec, input int nslot, input int bad_idx);
    int slots = 0;
    for (int i = 0; i < nvec; i++) begin
      step(1'b1, 1'b1, 1'b0, (i == bad_idx) ? 8'h01 : 8'h00);
      if ((i % 9 == 8) && (slots < nslot)) begin
        step(1'b1, 1'b0, 1'b0, 8'h00);
        slots++;
      end
    end
    while (slots < nslot) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      slots++;
    end
  endtask

  task automatic finish_run();
    step(1'b1, 1'b1, 1'b1, 8'hEE);
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic restart(input string tag);
    step(1'b1, 1'b1, 1'b0, 8'h77);
    chk({tag, "_sig_seed"}, 32'(signature_o), 32'h00);
    chk({tag, "_flags_clr"}, 32'({done_o, pass_o, fail_o, aborted_o, busy_o}), 32'h0);
  endtask

  initial begin
    rst_i      = 1'b1;
    running_i  = 1'b0;
    out_i      = 1'b0;
    bist_end_i = 1'b0;
    cut_resp_i = 8'h00;
    #12;
    chk("rst_sig", 32'(signature_o), 32'h00);
    chk("rst_flags", 32'({busy_o, done_o, pass_o, fail_o, aborted_o}), 32'h0);
    rst_i = 1'b0;

    // BIST_END in IDLE is ignored
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("idle_bend_ignored", 32'({busy_o, done_o, pass_o, fail_o}), 32'h0);

    // MISR seeding: 0x80 then 0x00 gives 0x80, 0x1D
    step(1'b1, 1'b1, 1'b0, 8'h80);
    chk("seed_first", 32'(signature_o), 32'h80);
    chk("seed_busy", 32'(busy_o), 32'h1);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("seed_second", 32'(signature_o), 32'h1D);
    rst_i = 1'b1; #2; rst_i = 1'b0;

    // single capture from reset
    step(1'b1, 1'b1, 1'b0, 8'hA5);
    chk("single_a5", 32'(signature_o), 32'hA5);
    rst_i = 1'b1; #2; rst_i = 1'b0;

    // async reset mid-COMPACT after 30 captures of 0xFF
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 8'hFF);
    chk("mid_busy", 32'(busy_o), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_sig", 32'(signature_o), 32'h00);
    chk("async_rst_flags", 32'({busy_o, done_o, pass_o, fail_o, aborted_o}), 32'h0);
    running_i = 1'b0;
    #3;
    rst_i = 1'b0;

    // nominal run
    run_body(72, 8, -1);
    step(1'b1, 1'b1, 1'b1, 8'hEE);
    chk("nom_compare_busy", 32'({busy_o, done_o, pass_o}), 32'b100);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("nom_sig", 32'(signature_o), 32'h00);
    chk("nom_result", 32'({done_o, pass_o, fail_o, aborted_o, busy_o}), 32'b11000);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("nom_hold", 32'({done_o, pass_o, fail_o}), 32'b110);

    // corrupted run
    restart("corr");
    run_body(72, 8, 5);
    finish_run();
    chk("corr_sig_nonzero", 32'(signature_o != 8'h00), 32'h1);
    chk("corr_result", 32'({done_o, pass_o, fail_o, aborted_o}), 32'b1010);

    // 71 captures
    restart("v71");
    run_body(71, 8, -1);
    finish_run();
    chk("v71_sig", 32'(signature_o), 32'h00);
    chk("v71_result", 32'({done_o, pass_o, fail_o}), 32'b101);

    // 7 boundary slots
    restart("g7");
    run_body(72, 7, -1);
    finish_run();
    chk("g7_sig", 32'(signature_o), 32'h00);
    chk("g7_result", 32'({done_o, pass_o, fail_o}), 32'b101);

    // abort after 40 captures, then restart
    restart("abt");
    run_body(40, 4, -1);
    chk("abt_pre_busy", 32'(busy_o), 32'h1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("abt_result", 32'({done_o, pass_o, fail_o, aborted_o, busy_o}), 32'b10110);
    step(1'b1, 1'b1, 1'b0, 8'h55);
    chk("abt_restart_sig", 32'(signature_o), 32'h00);
    chk("abt_restart_flags", 32'({done_o, pass_o, fail_o, aborted_o}), 32'h0);
    step(1'b1, 1'b1, 1'b0, 8'h55);
    chk("abt_first_capture", 32'(signature_o), 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
